// File: rtl/inst_fetch_unit_if.sv
// Fetch-unit bus bundle: PC-unit inputs, instruction-memory handshake and decode handshake.
interface inst_fetch_unit_if;
    logic [31:0] PC;
    logic [1:0]  NPCOp;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        dec_ready;
    logic        fetch_stall;

    // Fetch-unit side
    modport master (
        input  PC, NPCOp, imem_ack, imem_rdata, dec_ready,
        output imem_req, imem_addr, instr_valid, instr, instr_pc, fetch_stall
    );

    // Environment side: PC unit, instruction memory and decode
    modport slave (
        output PC, NPCOp, imem_ack, imem_rdata, dec_ready,
        input  imem_req, imem_addr, instr_valid, instr, instr_pc, fetch_stall
    );
endinterface

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: single-outstanding memory requests feeding a small
// circular instruction buffer, with redirect flush and discard of in-flight data.
module inst_fetch_unit #(
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic               clk,
    input  logic               PcReSet,
    inst_fetch_unit_if.master  bus
);
    localparam int unsigned PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_REQ  = 2'b01;
    localparam logic [1:0] ST_DROP = 2'b10;
    localparam logic [1:0] NPC_SEQ = 2'b00;

    logic [1:0]       state;
    logic [1:0]       state_next;
    logic             req_q;
    logic             req_next;
    logic [31:0]      addr_q;
    logic [31:0]      addr_next;
    logic             flush;
    logic             has_room;
    logic             push;
    logic             pop;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic [31:0]      buf_pc   [BUF_DEPTH];
    logic [31:0]      buf_word [BUF_DEPTH];

    // Next-state, request and buffer-control decode
    always_comb begin
        flush      = (bus.NPCOp != NPC_SEQ);
        has_room   = (count < DEPTH_C);
        pop        = (count != '0) && bus.dec_ready && !flush;
        state_next = state;
        req_next   = req_q;
        addr_next  = addr_q;
        push       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!flush && has_room) begin
                    req_next   = 1'b1;
                    addr_next  = bus.PC;
                    state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                if (bus.imem_ack) begin
                    req_next   = 1'b0;
                    push       = !flush;
                    state_next = ST_IDLE;
                end else if (flush) begin
                    state_next = ST_DROP;
                end
            end
            ST_DROP: begin
                // in-flight data belongs to the squashed path; wait it out and discard
                if (bus.imem_ack) begin
                    req_next   = 1'b0;
                    state_next = ST_IDLE;
                end
            end
            default: begin
                req_next   = 1'b0;
                state_next = ST_IDLE;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or posedge PcReSet) begin
        if (PcReSet) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Registered memory request and address
    always_ff @(posedge clk or posedge PcReSet) begin
        if (PcReSet) begin
            req_q  <= 1'b0;
            addr_q <= '0;
        end else begin
            req_q  <= req_next;
            addr_q <= addr_next;
        end
    end

    // Buffer pointers and occupancy; a flush wins over any push or pop
    always_ff @(posedge clk or posedge PcReSet) begin
        if (PcReSet) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Buffer storage; contents are only observable while count is non-zero
    always_ff @(posedge clk) begin
        if (push) begin
            buf_pc[wr_ptr]   <= addr_q;
            buf_word[wr_ptr] <= bus.imem_rdata;
        end
    end

    assign bus.imem_req    = req_q;
    assign bus.imem_addr   = addr_q;
    assign bus.instr_valid = (count != '0);
    assign bus.instr       = (count != '0) ? buf_word[rd_ptr] : '0;
    assign bus.instr_pc    = (count != '0) ? buf_pc[rd_ptr] : '0;
    assign bus.fetch_stall = !((state == ST_IDLE) && has_room) || flush;
endmodule
